// File: rtl/halloween_pkg.sv
// halloween_pkg: opcode, group and FSM state definitions shared by the sequencer
package halloween_pkg;
    localparam logic [3:0] OP_ON        = 4'h0;
    localparam logic [3:0] OP_RESET     = 4'h1;
    localparam logic [3:0] OP_GREEN     = 4'h4;
    localparam logic [3:0] OP_PURPLE    = 4'h5;
    localparam logic [3:0] OP_ORANGE    = 4'h6;
    localparam logic [3:0] OP_SCREAMING = 4'h8;
    localparam logic [3:0] OP_CACKLING  = 4'h9;
    localparam logic [3:0] OP_BOO       = 4'hA;
    localparam logic [3:0] OP_WAVEHANDS = 4'hC;
    localparam logic [3:0] OP_MOVEJAW   = 4'hD;
    localparam logic [3:0] OP_FOG       = 4'hE;
    localparam logic [1:0] GRP_SYS      = 2'b00;
    localparam logic [1:0] GRP_COLOR    = 2'b01;
    localparam logic [1:0] GRP_SOUND    = 2'b10;
    localparam logic [1:0] GRP_EFFECT   = 2'b11;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DWELL} seq_state_t;
endpackage

// File: rtl/halloween_sequencer_onehot_decoder.sv
// onehot_decoder: combinational binary to one-hot decode (in_i -> out_o, width 2**IN_W)
module onehot_decoder #(
    parameter int IN_W = 4
) (
    input  logic [IN_W-1:0]      in_i,
    output logic [2**IN_W-1:0]   out_o
);
    localparam int OUT_W = 2**IN_W;
    assign out_o = OUT_W'(1) << in_i;
endmodule

// File: rtl/halloween_sequencer.sv
// halloween_sequencer: steps through programmed opcode slots with a per-step dwell
// ports: clk/rst, enable_i run request, slot_data_i slot bank, dwell_cycles_i extra hold;
// registered slot_idx_o, opcode_o, onehot_o, group_o, op_valid_o, wrap_o, busy_o
module halloween_sequencer
    import halloween_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int OP_W      = 4,
    parameter int DWELL_W   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable_i,
    input  logic [NUM_SLOTS*OP_W-1:0]     slot_data_i,
    input  logic [DWELL_W-1:0]            dwell_cycles_i,
    output logic [$clog2(NUM_SLOTS)-1:0]  slot_idx_o,
    output logic [OP_W-1:0]               opcode_o,
    output logic [2**OP_W-1:0]            onehot_o,
    output logic [1:0]                    group_o,
    output logic                          op_valid_o,
    output logic                          wrap_o,
    output logic                          busy_o
);
    localparam int SW = $clog2(NUM_SLOTS);
    seq_state_t          state_q, state_d;
    logic [SW-1:0]       slot_q, slot_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [2**OP_W-1:0]  oh_q, oh_d, dec_oh;
    logic                valid_q, valid_d, wrap_q, wrap_d;
    logic [DWELL_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]     sample;
    logic                is_reset, last;
    assign sample   = slot_data_i[int'(slot_q)*OP_W +: OP_W];
    // RESET in slot 0 falls through as a NOP so an all-RESET program cannot livelock
    assign is_reset = (sample == OP_W'(OP_RESET)) && (slot_q != '0);
    assign last     = slot_q == SW'(NUM_SLOTS-1);
    onehot_decoder #(.IN_W(OP_W)) u_dec (.in_i(sample), .out_o(dec_oh));
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        op_d    = op_q;
        oh_d    = oh_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        if (!enable_i) begin
            state_d = S_IDLE;
            slot_d  = '0;
            op_d    = '0;
            oh_d    = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_LOAD;
                S_LOAD: begin
                    if (is_reset) begin
                        slot_d = '0;
                        wrap_d = 1'b1;
                    end else begin
                        op_d    = sample;
                        oh_d    = dec_oh;
                        valid_d = 1'b1;
                        cnt_d   = dwell_cycles_i;
                        state_d = S_DWELL;
                    end
                end
                S_DWELL: begin
                    if (cnt_q == '0) begin
                        slot_d  = last ? '0 : slot_q + 1'b1;
                        wrap_d  = last;
                        state_d = S_LOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            slot_q  <= '0;
            op_q    <= '0;
            oh_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            op_q    <= op_d;
            oh_q    <= oh_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end
    assign slot_idx_o = slot_q;
    assign opcode_o   = op_q;
    assign onehot_o   = oh_q;
    assign group_o    = op_q[OP_W-1 -: 2];
    assign op_valid_o = valid_q;
    assign wrap_o     = wrap_q;
    assign busy_o     = state_q != S_IDLE;
endmodule

// File: tb/tb_halloween_sequencer.sv
// tb_halloween_sequencer: randomized and directed check of both sequencer sizes against a step-level model
module tb_halloween_sequencer;
    import halloween_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic        en_a = 1'b0, en_b = 1'b0;
    logic [15:0] sd_a = '0;
    logic [39:0] sd_b = '0;
    logic [3:0]  dwell = '0;
    logic [1:0]  slot_a, grp_a;
    logic [3:0]  op_a;
    logic [15:0] oh_a;
    logic        v_a, w_a, b_a;
    logic [2:0]  slot_b;
    logic [1:0]  grp_b;
    logic [4:0]  op_b;
    logic [31:0] oh_b;
    logic        v_b, w_b, b_b;
    halloween_sequencer dut_a (
        .clk(clk), .rst(rst), .enable_i(en_a), .slot_data_i(sd_a), .dwell_cycles_i(dwell),
        .slot_idx_o(slot_a), .opcode_o(op_a), .onehot_o(oh_a), .group_o(grp_a),
        .op_valid_o(v_a), .wrap_o(w_a), .busy_o(b_a));
    halloween_sequencer #(.NUM_SLOTS(8), .OP_W(5), .DWELL_W(4)) dut_b (
        .clk(clk), .rst(rst), .enable_i(en_b), .slot_data_i(sd_b), .dwell_cycles_i(dwell),
        .slot_idx_o(slot_b), .opcode_o(op_b), .onehot_o(oh_b), .group_o(grp_b),
        .op_valid_o(v_b), .wrap_o(w_b), .busy_o(b_b));
    typedef struct {int slot; int op; logic [31:0] oh; bit v; bit w;} exp_t;
    bit sel_b = 1'b0;
    int n_slots = 4, w_op = 4, run_id = 0;
    int ops[8];
    int errors = 0, checks = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic check_obs(input string tag, input int slot, input int op, input logic [31:0] oh,
                             input bit v, input bit w, input bit busy);
        check({tag, " slot"},  sel_b ? 64'(slot_b) : 64'(slot_a), 64'(slot));
        check({tag, " op"},    sel_b ? 64'(op_b)   : 64'(op_a),   64'(op));
        check({tag, " oh"},    sel_b ? 64'(oh_b)   : 64'(oh_a),   64'(oh));
        check({tag, " grp"},   sel_b ? 64'(grp_b)  : 64'(grp_a),  64'((op >> (w_op-2)) & 3));
        check({tag, " valid"}, sel_b ? 64'(v_b)    : 64'(v_a),    64'(v));
        check({tag, " wrap"},  sel_b ? 64'(w_b)    : 64'(w_a),    64'(w));
        check({tag, " busy"},  sel_b ? 64'(b_b)    : 64'(b_a),    64'(busy));
    endtask
    task automatic set_a(input logic [15:0] d);
        sd_a = d; sel_b = 1'b0; n_slots = 4; w_op = 4;
        for (int k = 0; k < 4; k++) ops[k] = int'(d[k*4 +: 4]);
    endtask
    task automatic set_b(input logic [39:0] d);
        sd_b = d; sel_b = 1'b1; n_slots = 8; w_op = 5;
        for (int k = 0; k < 8; k++) ops[k] = int'(d[k*5 +: 5]);
    endtask
    // expected per-cycle outputs derived step by step from the program, starting at the first LOAD
    task automatic run(input int ncyc, input bit use_rst);
        exp_t q[$];
        int s = 0, cur = 0;
        logic [31:0] coh = '0;
        bit w = 1'b0;
        run_id++;
        while (q.size() < ncyc) begin
            q.push_back('{s, cur, coh, 1'b0, w});
            if (ops[s] == 1 && s != 0) begin
                s = 0;
                w = 1'b1;
            end else begin
                cur = ops[s];
                coh = 32'd1 << cur;
                for (int i = 0; i <= int'(dwell); i++) q.push_back('{s, cur, coh, bit'(i == 0), 1'b0});
                w = (s == n_slots-1);
                s = (s + 1) % n_slots;
            end
        end
        @(negedge clk);
        if (sel_b) en_b = 1'b1; else en_a = 1'b1;
        @(posedge clk);
        for (int c = 0; c < ncyc; c++) begin
            #1 check_obs($sformatf("run%0d c%0d", run_id, c), q[c].slot, q[c].op, q[c].oh, q[c].v, q[c].w, 1'b1);
            @(posedge clk);
        end
        if (use_rst) begin
            #3 rst = 1'b1;
            en_a = 1'b0; en_b = 1'b0;
            #1 check_obs($sformatf("run%0d async rst", run_id), 0, 0, 0, 0, 0, 0);
            @(negedge clk) rst = 1'b0;
        end else begin
            #1 en_a = 1'b0; en_b = 1'b0;
            @(posedge clk);
            #1 check_obs($sformatf("run%0d enable drop", run_id), 0, 0, 0, 0, 0, 0);
        end
        repeat (2) begin
            @(posedge clk);
            #1 check_obs($sformatf("run%0d idle hold", run_id), 0, 0, 0, 0, 0, 0);
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    initial begin
        logic [39:0] d;
        bit big;
        repeat (2) @(posedge clk);
        #1 check_obs("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk) rst = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1 check_obs("idle", 0, 0, 0, 0, 0, 0);
        end
        set_a({OP_MOVEJAW, 4'hF, OP_PURPLE, OP_GREEN});
        dwell = 4'd0; run(20, 1'b0);
        dwell = 4'd3; run(33, 1'b0);
        set_a(16'h1C86);
        dwell = 4'd0; run(24, 1'b0);
        set_a(16'h1111);
        dwell = 4'd1; run(20, 1'b0);
        set_a(16'hDF54);
        dwell = 4'd2; run(13, 1'b1);
        set_b({5'h1F, 5'h18, 5'h14, 5'h10, 5'h0C, 5'h08, 5'h1E, 5'h04});
        dwell = 4'd0; run(40, 1'b0);
        repeat (14) begin
            big = 1'($urandom_range(0, 1));
            d = '0;
            for (int k = 0; k < 8; k++)
                d[k*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'd1 : 5'($urandom);
            if (big) set_b(d);
            else set_a({d[3:0], d[8:5], d[13:10], d[18:15]});
            dwell = 4'($urandom_range(0, 3));
            run(int'($urandom_range(8, 40)), 1'($urandom_range(0, 1)));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
